// File: rtl/mux_8_to_1_if.sv
// mux_8_to_1 bus: eight source words, select/enable and registered result.
// Bit 0 is the MSB of every vector.
interface mux_8_to_1_if #(
  parameter int WIDTH = 32
);
  logic [0:WIDTH-1] a0;
  logic [0:WIDTH-1] a1;
  logic [0:WIDTH-1] a2;
  logic [0:WIDTH-1] a3;
  logic [0:WIDTH-1] a4;
  logic [0:WIDTH-1] a5;
  logic [0:WIDTH-1] a6;
  logic [0:WIDTH-1] a7;
  logic [0:2]       sel;
  logic             enb;
  logic [0:WIDTH-1] y;

  modport master (
    output a0, a1, a2, a3,
    output a4, a5, a6, a7,
    output sel, enb,
    input  y
  );

  modport slave (
    input  a0, a1, a2, a3,
    input  a4, a5, a6, a7,
    input  sel, enb,
    output y
  );
endinterface

// File: rtl/mux_8_to_1.sv
// Registered 8:1 word selector with output enable, async active-high reset.
// MUX_8_1_HOLD_EN: enb=0 holds y instead of clearing it.
module mux_8_to_1 #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  mux_8_to_1_if.slave  bus
);

  logic [0:WIDTH-1] sel_word;
  logic [0:WIDTH-1] y_q;
  logic [0:WIDTH-1] y_off;

  always_comb begin
    sel_word = '0;
    case (bus.sel)
      3'd0:    sel_word = bus.a0;
      3'd1:    sel_word = bus.a1;
      3'd2:    sel_word = bus.a2;
      3'd3:    sel_word = bus.a3;
      3'd4:    sel_word = bus.a4;
      3'd5:    sel_word = bus.a5;
      3'd6:    sel_word = bus.a6;
      3'd7:    sel_word = bus.a7;
      default: sel_word = 'x;
    endcase
  end

`ifdef MUX_8_1_HOLD_EN
  assign y_off = y_q;
`else
  assign y_off = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
    end else if (bus.enb) begin
      y_q <= sel_word;
    end else begin
      y_q <= y_off;
    end
  end

  assign bus.y = y_q;

endmodule

// File: tb/tb_mux_8_to_1.sv
// Directed bench for mux_8_to_1: reset, sweep, enable,
// data tracking, async reset and bit order.
module tb_mux_8_to_1;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fails;

  mux_8_to_1_if #(.WIDTH(32)) bus ();

  mux_8_to_1 #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp();
    bus.a0 = 32'h00010101;
    bus.a1 = 32'h00020202;
    bus.a2 = 32'h00030303;
    bus.a3 = 32'h00040404;
    bus.a4 = 32'h00050505;
    bus.a5 = 32'h00060606;
    bus.a6 = 32'h00070707;
    bus.a7 = 32'h00080808;
  endtask

  logic [31:0] ramp [8];
  logic [31:0] y_word;
  logic [31:0] off_exp;

  initial begin
    n_tests = 0;
    n_fails = 0;
    ramp = '{32'h00010101, 32'h00020202, 32'h00030303,
             32'h00040404, 32'h00050505, 32'h00060606,
             32'h00070707, 32'h00080808};
    rst = 1'b0;
    load_ramp();
    bus.sel = 3'd3;
    bus.enb = 1'b1;
    #1 rst = 1'b1;
    #1 check("rst_async", bus.y, 32'h0);
    tick();
    check("rst_edge1", bus.y, 32'h0);
    #3 check("rst_mid", bus.y, 32'h0);
    tick();
    check("rst_edge2", bus.y, 32'h0);
    rst = 1'b0;
    tick();
    check("rst_release", bus.y, 32'h00040404);

    for (int i = 0; i < 8; i++) begin
      bus.sel = 3'(i);
      tick();
      check($sformatf("sweep%0d", i), bus.y, ramp[i]);
    end

`ifdef MUX_8_1_HOLD_EN
    off_exp = 32'h00080808;
`else
    off_exp = 32'h0;
`endif
    bus.sel = 3'd5;
    bus.enb = 1'b0;
    tick();
    check("enb_off", bus.y, off_exp);
    bus.enb = 1'b1;
    tick();
    check("enb_on", bus.y, 32'h00060606);

    bus.sel = 3'd2;
    tick();
    check("data_base", bus.y, 32'h00030303);
    bus.a2 = 32'hFFFFFFFF;
    #1 check("data_latency", bus.y, 32'h00030303);
    tick();
    check("data_follow", bus.y, 32'hFFFFFFFF);
    bus.a0 = 32'hDEADBEEF;
    bus.a1 = 32'h12345678;
    bus.a3 = 32'hA5A5A5A5;
    bus.a7 = 32'h0F0F0F0F;
    tick();
    check("data_others", bus.y, 32'hFFFFFFFF);
    load_ramp();

    bus.sel = 3'd7;
    tick();
    check("pre_reset", bus.y, 32'h00080808);
    #2 rst = 1'b1;
    #1 check("async_clear", bus.y, 32'h0);
    tick();
    check("async_hold", bus.y, 32'h0);
    rst = 1'b0;
    bus.sel = 3'd0;
    tick();
    check("async_recover", bus.y, 32'h00010101);

    bus.a1 = 32'h80000000;
    bus.sel = 3'd1;
    tick();
    y_word = bus.y;
    check("bit0_msb", {31'd0, bus.y[0]}, 32'h1);
    check("bit_order", y_word, 32'h80000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

// File: doc/mux_8_to_1.md
Name: mux_8_to_1

Overview:
- Eight-input, WIDTH-bit word selector with a registered output and an output enable.
- Used in VCPU-32 datapath stages to pick one of eight operand or result sources.
- The selected word appears on y one clock after sel/enb/inputs are sampled.
- Asynchronous active-high reset clears the output register.

Parameters:
- WIDTH, 32, data width of each input word and of y. Bit 0 is the MSB; vectors are declared [0:WIDTH-1].

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous reset, active-high
- a0  input  WIDTH  data input, selected when sel=0
- a1  input  WIDTH  data input, selected when sel=1
- a2  input  WIDTH  data input, selected when sel=2
- a3  input  WIDTH  data input, selected when sel=3
- a4  input  WIDTH  data input, selected when sel=4
- a5  input  WIDTH  data input, selected when sel=5
- a6  input  WIDTH  data input, selected when sel=6
- a7  input  WIDTH  data input, selected when sel=7
- sel  input  3 ([0:2], bit 0 = MSB)  source select, unsigned 0..7
- enb  input  1  output enable, active-high
- y  output  WIDTH  registered selected word

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset:
  - rst high forces y = 0 immediately, without waiting for a clock edge.
  - y stays 0 while rst is held.
  - The first rising clk edge with rst low loads a normal value.
- Rising clk edge, rst low:
  - enb=1: y <= a[sel], where a[n] is input a<n>.
  - enb=0: y <= 0 (default build).
- Latency: exactly 1 clk cycle from sel/enb/data sampled to y updated. There is no combinational path from any input to y.
- Selection is a full decode of all 8 codes; every code is legal.
- Words pass through bit-exact: no sign or zero manipulation, bit n of y = bit n of the selected input.
- Inputs may change every cycle.
- Simultaneous changes of sel and the data inputs in one cycle: the value present at the clk edge is used.
- sel or enb containing X/Z at a clock edge: y takes X in simulation; no recovery logic is required.
- rst asserted mid-operation: y clears asynchronously. Recovery is as in normal operation, with no additional state.
- Internal state is the y register only.

Optional Feature:
- Macro: MUX_8_1_HOLD_EN
- Defined: when enb=0 at a clock edge, y keeps its previous value instead of loading 0. Reset still clears y to 0.
- Not defined: enb=0 loads y with 0, as in Behaviour.
- Nothing else changes: ports, latency and the enb=1 path are identical in both builds.

Test Plan:
- Reset: hold rst=1 with sel=3, enb=1 and inputs active -> y = 0x00000000, including between clock edges. Release rst -> y = 0x00040404 after the first edge.
- Sweep: a0..a7 = 0x00010101, 0x00020202, 0x00030303, 0x00040404, 0x00050505, 0x00060606, 0x00070707, 0x00080808; enb=1; sel stepped 0..7, one code per cycle -> y lags sel by one cycle and equals 0x00010101 .. 0x00080808 in order.
- Enable: sel=5, enb=0 for one edge -> y = 0 (default build) or the previous value held (MUX_8_1_HOLD_EN). enb back to 1 -> y = 0x00060606 after the next edge.
- Data change with sel fixed at 2: a2 changes 0x00030303 -> 0xFFFFFFFF -> y follows one cycle later. Changes on the other inputs leave y unaffected.
- Async reset mid-stream: assert rst between clock edges while y = 0x00080808 -> y = 0 before the next edge. Deassert rst with sel=0 -> y = 0x00010101 after the next edge.
- Bit order: a1 = 0x80000000, sel=1 -> y bit 0 (MSB) = 1 and all other bits = 0.
